// File: rtl/cpu7_csr_timer_array_if.sv
// CSR read/write port and interrupt outputs of the cpu7 CSR timer array.
interface cpu7_csr_timer_array_if #(
   parameter int unsigned NTIMER  = 4,
   parameter int unsigned GRLEN   = 32,
   parameter int unsigned CSR_BIT = 14
);
   logic [CSR_BIT-1:0] csr_raddr;
   logic [GRLEN-1:0]   csr_rdata;
   logic [CSR_BIT-1:0] csr_waddr;
   logic [GRLEN-1:0]   csr_wdata;
   logic [GRLEN-1:0]   csr_mask;
   logic               csr_wen;
   logic [NTIMER-1:0]  timer_intr;
   logic               timer_intr_any;

   modport master (
      output csr_raddr, csr_waddr, csr_wdata, csr_mask, csr_wen,
      input  csr_rdata, timer_intr, timer_intr_any
   );

   modport slave (
      input  csr_raddr, csr_waddr, csr_wdata, csr_mask, csr_wen,
      output csr_rdata, timer_intr, timer_intr_any
   );
endinterface

// File: rtl/cpu7_csr_timer_array.sv
// NTIMER independent countdown timers (TCFG/TVAL/TICLR per channel) on the CSR port.
// Optional shared tick prescaler enabled by defining CPU7_CSR_TIMER_PRESCALE_EN.
module cpu7_csr_timer_array #(
   parameter int unsigned        NTIMER       = 4,
   parameter int unsigned        GRLEN        = 32,
   parameter int unsigned        TIMER_BIT    = 32,
   parameter int unsigned        CSR_BIT      = 14,
   parameter logic [CSR_BIT-1:0] TBASE        = 14'h41,
   parameter int unsigned        PRESCALE_DIV = 4
) (
   input logic                   clk,
   input logic                   resetn,
   cpu7_csr_timer_array_if.slave csr
);

   function automatic logic [CSR_BIT-1:0] reg_addr(input int unsigned ch, input int unsigned off);
      return CSR_BIT'(32'(TBASE) + 4 * ch + off);
   endfunction

   function automatic logic [TIMER_BIT-1:0] reload(input logic [TIMER_BIT-1:0] cfg);
      return {cfg[TIMER_BIT-1:2], 2'b00};
   endfunction

   logic tick;

`ifdef CPU7_CSR_TIMER_PRESCALE_EN
   localparam int unsigned PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;

   always_comb begin
      tick  = (pre_q == PW'(PRESCALE_DIV - 1));
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) pre_q <= '0;
      else         pre_q <= pre_d;
   end
`else
   logic [31:0] unused_prescale_div;

   assign tick                = 1'b1;
   assign unused_prescale_div = 32'(PRESCALE_DIV);
`endif

   logic [TIMER_BIT-1:0] cfg_q   [NTIMER];
   logic [TIMER_BIT-1:0] cfg_d   [NTIMER];
   logic [TIMER_BIT-1:0] cfg_new [NTIMER];
   logic [TIMER_BIT-1:0] cnt_q   [NTIMER];
   logic [TIMER_BIT-1:0] cnt_d   [NTIMER];
   logic [NTIMER-1:0]    pend_q, pend_d;
   logic [NTIMER-1:0]    cfg_wr, clr_wr, expire;
   logic [GRLEN-1:0]     rdata;

   // Expire is judged on pre-write state, so a same-cycle TCFG write still sets pending.
   always_comb begin
      for (int unsigned i = 0; i < NTIMER; i++) begin
         cfg_wr[i]  = csr.csr_wen && (csr.csr_waddr == reg_addr(i, 0));
         clr_wr[i]  = csr.csr_wen && (csr.csr_waddr == reg_addr(i, 3))
                      && csr.csr_wdata[0] && csr.csr_mask[0];
         cfg_new[i] = (cfg_q[i] & ~csr.csr_mask[TIMER_BIT-1:0])
                      | (csr.csr_wdata[TIMER_BIT-1:0] & csr.csr_mask[TIMER_BIT-1:0]);
         expire[i]  = tick && cfg_q[i][0] && (cnt_q[i] == TIMER_BIT'(1));
         cfg_d[i]   = cfg_wr[i] ? cfg_new[i] : cfg_q[i];
         cnt_d[i]   = cnt_q[i];
         if (cfg_wr[i])
            cnt_d[i] = reload(cfg_new[i]);
         else if (expire[i])
            cnt_d[i] = cfg_q[i][1] ? reload(cfg_q[i]) : '0;
         else if (tick && cfg_q[i][0] && (cnt_q[i] != '0))
            cnt_d[i] = cnt_q[i] - 1'b1;
         pend_d[i]  = expire[i] | (pend_q[i] & ~clr_wr[i]);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_q <= '0;
         for (int unsigned i = 0; i < NTIMER; i++) begin
            cfg_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         pend_q <= pend_d;
         for (int unsigned i = 0; i < NTIMER; i++) begin
            cfg_q[i] <= cfg_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < NTIMER; i++) begin
         if (csr.csr_raddr == reg_addr(i, 0))      rdata = GRLEN'(cfg_q[i]);
         else if (csr.csr_raddr == reg_addr(i, 1)) rdata = GRLEN'(cnt_q[i]);
      end
   end

   assign csr.csr_rdata      = rdata;
   assign csr.timer_intr     = pend_q;
   assign csr.timer_intr_any = |pend_q;

endmodule
